// File: rtl/iter_divider_if.sv
// EXE-stage divider port bundle: operand buses, start/flush control and the
// busy/done/result return path.
interface iter_divider_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] EXE_ResultA;
   logic [WIDTH-1:0] EXE_ResultB;
   logic             div_start;
   logic             div_signed;
   logic             flush;
   logic             div_busy;
   logic             div_done;
   logic [WIDTH-1:0] div_quot;
   logic [WIDTH-1:0] div_rem;

   modport master (
      output EXE_ResultA, EXE_ResultB, div_start, div_signed, flush,
      input  div_busy, div_done, div_quot, div_rem
   );

   modport slave (
      input  EXE_ResultA, EXE_ResultB, div_start, div_signed, flush,
      output div_busy, div_done, div_quot, div_rem
   );
endinterface

// File: rtl/iter_divider.sv
// Restoring radix-2 divider for DIV/DIVU: one quotient bit per cycle on
// magnitudes, sign fixup registered on the final iteration.
module iter_divider #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           resetn,
   iter_divider_if.slave div_if
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] part_reg, part_next;
   logic [2*WIDTH:0]   shifted;
   logic [WIDTH:0]     trial;
   logic               sign_q_reg, sign_r_reg, dbz_reg;
   logic [WIDTH-1:0]   a_raw_reg, b_mag_reg;
   logic [WIDTH-1:0]   quot_reg, rem_reg;
   logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
   logic               accept, last_iter, finish;

   assign accept    = (state_reg == IDLE) && div_if.div_start && !div_if.flush;
   assign last_iter = (state_reg == CALC) && (cnt_reg == CW'(WIDTH - 1));
   assign finish    = last_iter && !div_if.flush;

   assign a_mag = (div_if.div_signed && div_if.EXE_ResultA[WIDTH-1]) ? -div_if.EXE_ResultA
                                                                     : div_if.EXE_ResultA;
   assign b_mag = (div_if.div_signed && div_if.EXE_ResultB[WIDTH-1]) ? -div_if.EXE_ResultB
                                                                     : div_if.EXE_ResultB;

   // Upper WIDTH+1 bits of the shifted remainder hold the trial window;
   // the borrow bit tells whether the divisor fits.
   always_comb begin
      shifted = {part_reg, 1'b0};
      trial   = shifted[2*WIDTH:WIDTH] - {1'b0, b_mag_reg};
      if (!trial[WIDTH]) begin
         part_next = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
      end else begin
         part_next = shifted[2*WIDTH-1:0];
      end
   end

   assign q_mag = part_next[WIDTH-1:0];
   assign r_mag = part_next[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      div_if.div_busy = 1'b0;
      div_if.div_done = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) state_next = CALC;
         end
         CALC: begin
            div_if.div_busy = 1'b1;
            if (last_iter) state_next = DONE;
         end
         DONE: begin
            div_if.div_done = 1'b1;
            state_next      = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (div_if.flush) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt_reg    <= '0;
         part_reg   <= '0;
         sign_q_reg <= 1'b0;
         sign_r_reg <= 1'b0;
         dbz_reg    <= 1'b0;
         a_raw_reg  <= '0;
         b_mag_reg  <= '0;
         quot_reg   <= '0;
         rem_reg    <= '0;
      end else begin
         if (accept) begin
            sign_q_reg <= div_if.div_signed & (div_if.EXE_ResultA[WIDTH-1] ^ div_if.EXE_ResultB[WIDTH-1]);
            sign_r_reg <= div_if.div_signed & div_if.EXE_ResultA[WIDTH-1];
            dbz_reg    <= (div_if.EXE_ResultB == '0);
            a_raw_reg  <= div_if.EXE_ResultA;
            b_mag_reg  <= b_mag;
            cnt_reg    <= '0;
            part_reg   <= {{WIDTH{1'b0}}, a_mag};
         end else if (state_reg == CALC) begin
            part_reg <= part_next;
            cnt_reg  <= cnt_reg + CW'(1);
         end
         // Divide-by-zero returns all-ones / raw dividend, matching the ISA convention.
         if (finish) begin
            quot_reg <= dbz_reg ? '1 : (sign_q_reg ? -q_mag : q_mag);
            rem_reg  <= dbz_reg ? a_raw_reg : (sign_r_reg ? -r_mag : r_mag);
         end
      end
   end

   assign div_if.div_quot = quot_reg;
   assign div_if.div_rem  = rem_reg;
endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: results, latency, flush/reset aborts and
// back-to-back throughput against hand-computed values.
module tb_iter_divider;
   logic clk;
   logic resetn;
   int   checks;
   int   errors;
   logic [31:0] last_q;
   logic [31:0] last_r;

   iter_divider_if #(.WIDTH(32)) dif ();

   iter_divider #(.WIDTH(32)) dut (
      .clk    (clk),
      .resetn (resetn),
      .div_if (dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Accepts on the next edge, scrambles the operand buses afterwards and
   // waits (bounded) for div_done; leaves div_start low on return.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int lat, output int busy_cnt);
      dif.EXE_ResultA = a;
      dif.EXE_ResultB = b;
      dif.div_signed  = sgn;
      dif.div_start   = 1'b1;
      @(posedge clk); #1;
      dif.EXE_ResultA = ~a;
      dif.EXE_ResultB = b ^ 32'h5A5A_0F0F;
      dif.div_signed  = ~sgn;
      lat      = 0;
      busy_cnt = 0;
      while (!dif.div_done && lat < 60) begin
         if (dif.div_busy) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
      dif.div_start = 1'b0;
   endtask

   task automatic test_reset();
      resetn          = 1'b0;
      dif.EXE_ResultA = '0;
      dif.EXE_ResultB = '0;
      dif.div_start   = 1'b0;
      dif.div_signed  = 1'b0;
      dif.flush       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dif.div_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", dif.div_busy); end
      checks++;
      if (dif.div_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", dif.div_done); end
      checks++;
      if (dif.div_quot !== 32'h0) begin errors++; $display("FAIL reset_quot got %h expected 0", dif.div_quot); end
      checks++;
      if (dif.div_rem !== 32'h0) begin errors++; $display("FAIL reset_rem got %h expected 0", dif.div_rem); end
      resetn = 1'b1;
      @(posedge clk); #1;
      last_q = 32'h0;
      last_r = 32'h0;
   endtask

   task automatic test_divide(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic sgn, input logic [31:0] exp_q, input logic [31:0] exp_r);
      int lat, busy_cnt;
      do_div(a, b, sgn, lat, busy_cnt);
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL %s latency got %0d expected 32", name, lat); end
      checks++;
      if (busy_cnt !== 32) begin errors++; $display("FAIL %s busy_cycles got %0d expected 32", name, busy_cnt); end
      checks++;
      if (dif.div_quot !== exp_q) begin errors++; $display("FAIL %s quot got %h expected %h", name, dif.div_quot, exp_q); end
      checks++;
      if (dif.div_rem !== exp_r) begin errors++; $display("FAIL %s rem got %h expected %h", name, dif.div_rem, exp_r); end
      @(posedge clk); #1;
      checks++;
      if ({dif.div_busy, dif.div_done} !== 2'b00) begin
         errors++; $display("FAIL %s idle_after got busy/done %b expected 00", name, {dif.div_busy, dif.div_done});
      end
      $display("div %s a=%h b=%h signed=%b -> quot=%h rem=%h lat=%0d", name, a, b, sgn, dif.div_quot, dif.div_rem, lat);
      last_q = exp_q;
      last_r = exp_r;
   endtask

   task automatic test_flush_mid();
      int lat, busy_cnt;
      dif.EXE_ResultA = 32'd1000;
      dif.EXE_ResultB = 32'd7;
      dif.div_signed  = 1'b0;
      dif.div_start   = 1'b1;
      @(posedge clk); #1;
      repeat (9) begin @(posedge clk); #1; end
      checks++;
      if (dif.div_busy !== 1'b1) begin errors++; $display("FAIL flush_mid_busy_before got %b expected 1", dif.div_busy); end
      dif.flush     = 1'b1;
      dif.div_start = 1'b0;
      @(posedge clk); #1;
      dif.flush = 1'b0;
      checks++;
      if ({dif.div_busy, dif.div_done} !== 2'b00) begin
         errors++; $display("FAIL flush_mid_state got busy/done %b expected 00", {dif.div_busy, dif.div_done});
      end
      checks++;
      if (dif.div_quot !== last_q || dif.div_rem !== last_r) begin
         errors++; $display("FAIL flush_mid_hold got %h/%h expected %h/%h", dif.div_quot, dif.div_rem, last_q, last_r);
      end
      $display("flush mid-CALC: busy=%b done=%b quot=%h rem=%h", dif.div_busy, dif.div_done, dif.div_quot, dif.div_rem);
      do_div(32'd1000, 32'd3, 1'b0, lat, busy_cnt);
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL flush_restart_latency got %0d expected 32", lat); end
      checks++;
      if (dif.div_quot !== 32'd333 || dif.div_rem !== 32'd1) begin
         errors++; $display("FAIL flush_restart_result got %h/%h expected 0000014d/00000001", dif.div_quot, dif.div_rem);
      end
      $display("restart 1000/3 -> quot=%h rem=%h lat=%0d", dif.div_quot, dif.div_rem, lat);
      last_q = 32'd333;
      last_r = 32'd1;
      @(posedge clk); #1;
   endtask

   task automatic test_flush_last();
      dif.EXE_ResultA = 32'd50;
      dif.EXE_ResultB = 32'd7;
      dif.div_signed  = 1'b0;
      dif.div_start   = 1'b1;
      @(posedge clk); #1;
      dif.div_start = 1'b0;
      repeat (31) begin @(posedge clk); #1; end
      checks++;
      if (dif.div_busy !== 1'b1) begin errors++; $display("FAIL flush_last_busy got %b expected 1", dif.div_busy); end
      dif.flush = 1'b1;
      @(posedge clk); #1;
      dif.flush = 1'b0;
      checks++;
      if ({dif.div_busy, dif.div_done} !== 2'b00) begin
         errors++; $display("FAIL flush_last_state got busy/done %b expected 00", {dif.div_busy, dif.div_done});
      end
      checks++;
      if (dif.div_quot !== last_q || dif.div_rem !== last_r) begin
         errors++; $display("FAIL flush_last_hold got %h/%h expected %h/%h", dif.div_quot, dif.div_rem, last_q, last_r);
      end
      @(posedge clk); #1;
      checks++;
      if (dif.div_done !== 1'b0) begin errors++; $display("FAIL flush_last_late_done got %b expected 0", dif.div_done); end
      $display("flush on final edge: quot=%h rem=%h", dif.div_quot, dif.div_rem);
   endtask

   task automatic test_flush_done();
      int lat, busy_cnt;
      do_div(32'd9, 32'd4, 1'b0, lat, busy_cnt);
      dif.flush = 1'b1;
      #1;
      checks++;
      if (dif.div_done !== 1'b1) begin errors++; $display("FAIL flush_done_pulse got %b expected 1", dif.div_done); end
      @(posedge clk); #1;
      dif.flush = 1'b0;
      checks++;
      if ({dif.div_busy, dif.div_done} !== 2'b00) begin
         errors++; $display("FAIL flush_done_state got busy/done %b expected 00", {dif.div_busy, dif.div_done});
      end
      checks++;
      if (dif.div_quot !== 32'd2 || dif.div_rem !== 32'd1) begin
         errors++; $display("FAIL flush_done_result got %h/%h expected 00000002/00000001", dif.div_quot, dif.div_rem);
      end
      $display("flush during DONE: quot=%h rem=%h", dif.div_quot, dif.div_rem);
      last_q = 32'd2;
      last_r = 32'd1;
   endtask

   task automatic test_reset_mid();
      dif.EXE_ResultA = 32'd100;
      dif.EXE_ResultB = 32'd7;
      dif.div_signed  = 1'b0;
      dif.div_start   = 1'b1;
      @(posedge clk); #1;
      dif.div_start = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      checks++;
      if ({dif.div_busy, dif.div_done} !== 2'b00) begin
         errors++; $display("FAIL reset_mid_state got busy/done %b expected 00", {dif.div_busy, dif.div_done});
      end
      checks++;
      if (dif.div_quot !== 32'h0 || dif.div_rem !== 32'h0) begin
         errors++; $display("FAIL reset_mid_results got %h/%h expected 0/0", dif.div_quot, dif.div_rem);
      end
      @(posedge clk); #1;
      checks++;
      if ({dif.div_busy, dif.div_done} !== 2'b00) begin
         errors++; $display("FAIL reset_mid_after got busy/done %b expected 00", {dif.div_busy, dif.div_done});
      end
      $display("reset mid-CALC: busy=%b done=%b quot=%h rem=%h", dif.div_busy, dif.div_done, dif.div_quot, dif.div_rem);
      last_q = 32'h0;
      last_r = 32'h0;
   endtask

   task automatic test_back_to_back();
      int n, pulses, t1, t2;
      logic [31:0] q1, r1, q2, r2;
      pulses = 0; t1 = -1; t2 = -1;
      q1 = '0; r1 = '0; q2 = '0; r2 = '0;
      dif.EXE_ResultA = 32'd100;
      dif.EXE_ResultB = 32'd7;
      dif.div_signed  = 1'b0;
      dif.div_start   = 1'b1;
      @(posedge clk); #1;
      dif.EXE_ResultA = 32'hFFFF_FFF9;
      dif.EXE_ResultB = 32'h2;
      dif.div_signed  = 1'b1;
      for (n = 1; n <= 70; n++) begin
         @(posedge clk); #1;
         if (dif.div_done) begin
            pulses++;
            if (pulses == 1) begin t1 = n; q1 = dif.div_quot; r1 = dif.div_rem; end
            if (pulses == 2) begin t2 = n; q2 = dif.div_quot; r2 = dif.div_rem; end
         end
      end
      dif.div_start = 1'b0;
      dif.flush     = 1'b1;
      @(posedge clk); #1;
      dif.flush = 1'b0;
      checks++;
      if (t1 !== 32) begin errors++; $display("FAIL b2b_first_done_edge got %0d expected 32", t1); end
      checks++;
      if (t2 !== 66) begin errors++; $display("FAIL b2b_second_done_edge got %0d expected 66", t2); end
      checks++;
      if (pulses !== 2) begin errors++; $display("FAIL b2b_pulse_count got %0d expected 2", pulses); end
      checks++;
      if (q1 !== 32'd14 || r1 !== 32'd2) begin
         errors++; $display("FAIL b2b_first_result got %h/%h expected 0000000e/00000002", q1, r1);
      end
      checks++;
      if (q2 !== 32'hFFFF_FFFD || r2 !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL b2b_second_result got %h/%h expected fffffffd/ffffffff", q2, r2);
      end
      $display("back-to-back: done at E%0d (%h/%h) and E%0d (%h/%h)", t1, q1, r1, t2, q2, r2);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_divide("udiv_100_7",    32'd100,         32'd7,           1'b0, 32'd14,         32'd2);
      test_divide("sdiv_m7_2",     32'hFFFF_FFF9,   32'h2,           1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
      test_divide("sdiv_7_m2",     32'd7,           32'hFFFF_FFFE,   1'b1, 32'hFFFF_FFFD,  32'd1);
      test_divide("sdiv_by_zero",  32'h1234_5678,   32'h0,           1'b1, 32'hFFFF_FFFF,  32'h1234_5678);
      test_divide("udiv_by_zero",  32'h1234_5678,   32'h0,           1'b0, 32'hFFFF_FFFF,  32'h1234_5678);
      test_divide("sdiv_neg_zero", 32'h8765_4321,   32'h0,           1'b1, 32'hFFFF_FFFF,  32'h8765_4321);
      test_divide("sdiv_min_m1",   32'h8000_0000,   32'hFFFF_FFFF,   1'b1, 32'h8000_0000,  32'h0);
      test_divide("udiv_max_1",    32'hFFFF_FFFF,   32'd1,           1'b0, 32'hFFFF_FFFF,  32'h0);
      test_divide("sdiv_zero_m5",  32'h0,           32'hFFFF_FFFB,   1'b1, 32'h0,          32'h0);
      test_divide("udiv_big",      32'hFFFF_FFFF,   32'h0001_0000,   1'b0, 32'h0000_FFFF,  32'h0000_FFFF);
      test_divide("udiv_100_7_b",  32'd100,         32'd7,           1'b0, 32'd14,         32'd2);
      test_flush_mid();
      test_flush_last();
      test_flush_done();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
